neuron_update_ctrl: RTL
=======================

Name: neuron_update_ctrl

Overview:
Timestep sequencer for a bank of NUM_NEURONS membrane-potential registers. Each register is an enable-gated flop with active-low reset.
- On each `tick`, walks neuron indices 0..NUM_NEURONS-1 through the shared integrate/threshold datapath.
- Drives the read-select `sel` and a one-hot write enable per neuron.
- Collects threshold-crossing results into a spike vector and count for the next layer.
- Sits between the global timestep generator and the neuron register bank plus its datapath.

Parameters:
- NUM_NEURONS, 4: number of neuron state registers sequenced; must be >= 2.
- IDX_W, $clog2(NUM_NEURONS): width of `sel`.
- CNT_W, $clog2(NUM_NEURONS+1): width of `spike_cnt`.
- REFRAC_STEPS, 2: timesteps a neuron is held after spiking (used only with REFRACTORY_EN).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- tick, input, 1: start-of-timestep request, single-cycle pulse.
- spike_in, input, 1: datapath threshold-compare result for neuron `sel`; valid in the WRITE state.
- sel, output, IDX_W: neuron index presented to the datapath read mux.
- en, output, NUM_NEURONS: one-hot write enable to the neuron registers.
- v_clr, output, 1: datapath selects the membrane reset value instead of the integrated value.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse when a timestep completes.
- spike_vec, output, NUM_NEURONS: spikes of the last completed timestep.
- spike_cnt, output, CNT_W: population count of `spike_vec`.
- overrun, output, 1: sticky; set when `tick` arrives while busy.

Behaviour:
- Reset (async, rst=0) values:
  - state=IDLE; sel=0; en=0; v_clr=0; busy=0; done=0; spike_vec=0; spike_cnt=0; overrun=0.
  - Refractory counters=0.
  - Reset mid-timestep aborts immediately. No partial `done`. `spike_vec` is cleared.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - `tick`=1 -> LOAD. Same edge: sel<=0 and the spike accumulator is cleared.
  - `spike_vec` and `spike_cnt` keep the previous timestep result until DONE.
- LOAD: one cycle for datapath settle; en=0 -> WRITE.
- WRITE:
  - en[sel]=1; all other en bits 0.
  - v_clr = spike_in (combinational, qualified by the WRITE state).
  - Accumulator bit [sel] <= spike_in.
  - If sel==NUM_NEURONS-1 -> DONE; else sel<=sel+1 -> LOAD.
- DONE:
  - done=1 for exactly one cycle; en=0.
  - spike_vec <= accumulator; spike_cnt <= popcount(accumulator). Both are visible in the cycle after DONE and held until the next DONE.
  - -> IDLE, sel<=0.
- Latency: `tick` sampled at edge t -> `done` high in cycle t+1+2*NUM_NEURONS.
- en is always one-hot or zero; never more than one bit set.
- tick while busy (LOAD, WRITE or DONE):
  - Ignored; no restart, no queuing.
  - overrun<=1. It stays set until reset.
- tick in the same cycle as DONE counts as an overrun. It is not accepted.
- spike_in outside WRITE: don't-care, no effect.
- sel wrap: it never exceeds NUM_NEURONS-1. Non-power-of-two NUM_NEURONS must not visit unused indices.

Optional Feature:
Macro: NEURON_REFRACTORY_EN
- Defined:
  - Each neuron has a counter of width $clog2(REFRAC_STEPS+1).
  - On WRITE with spike_in=1, the counter loads REFRAC_STEPS.
  - On later visits with counter!=0: WRITE asserts en[sel]=1 and v_clr=1 (potential held at reset value), accumulator bit=0, and the counter decrements.
  - spike_in is ignored while the counter is non-zero.
- Undefined: no counters; behaviour is exactly as above.
- Cycle timing is identical in both builds.

Test Plan:
All scenarios use NUM_NEURONS=4.
1. Reset -> all outputs 0. Release rst, tick at cycle 0 -> sel sequence 0,0,1,1,2,2,3,3; en 0000,0001,0000,0010,0000,0100,0000,1000; done at cycle 9; busy cycles 1-9.
2. spike_in=1 only in WRITE of neurons 1 and 3 -> v_clr pulses in those cycles; after done, spike_vec=1010 and spike_cnt=2.
3. Second tick with no spikes -> spike_vec holds 1010 through the run, then 0000 and spike_cnt=0 after done.
4. tick at cycle 4 (mid-run) and again in the DONE cycle -> run unaffected, done at cycle 9, overrun=1 and sticky. A new tick in IDLE still starts a run.
5. rst asserted asynchronously mid-WRITE of neuron 2 -> en=0, state IDLE, spike_vec=0 immediately with no clock edge; no done pulse.
6. With NEURON_REFRACTORY_EN and REFRAC_STEPS=2, neuron 0 spikes in step 1 with spike_in forced to 1 for all steps -> spike_vec[0]=1,0,0,1 over steps 1-4. In steps 2-3 WRITE of neuron 0 shows en[0]=1 and v_clr=1.

Source files
------------

// File: rtl/neuron_update_ctrl.sv
// Timestep sequencer for a bank of membrane-potential registers.
// Optional refractory hold: define NEURON_REFRACTORY_EN.
module neuron_update_ctrl #(
   parameter int NUM_NEURONS  = 4,
   parameter int IDX_W        = $clog2(NUM_NEURONS),
   parameter int CNT_W        = $clog2(NUM_NEURONS + 1),
   parameter int REFRAC_STEPS = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick,
   input  logic                   spike_in,
   output logic [IDX_W-1:0]       sel,
   output logic [NUM_NEURONS-1:0] en,
   output logic                   v_clr,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_NEURONS-1:0] spike_vec,
   output logic [CNT_W-1:0]       spike_cnt,
   output logic                   overrun
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      DONE
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [IDX_W-1:0]         sel_nxt;
   logic [NUM_NEURONS-1:0]   acc;
   logic [NUM_NEURONS-1:0]   acc_nxt;
   logic                     last;
   logic                     hold;

   assign last = (sel == IDX_W'(NUM_NEURONS - 1));
   assign busy = (state != IDLE);

   function automatic logic [CNT_W-1:0] popcnt(
      input logic [NUM_NEURONS-1:0] v
   );
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_NEURONS; i++)
         c = c + CNT_W'(v[i]);
      return c;
   endfunction

`ifdef NEURON_REFRACTORY_EN
   localparam int RW = $clog2(REFRAC_STEPS + 1);

   logic [RW-1:0] rcnt [NUM_NEURONS];

   assign hold = (rcnt[sel] != '0);

   // A held neuron burns one step of its refractory budget per visit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_NEURONS; i++)
            rcnt[i] <= '0;
      end else if (state == WRITE) begin
         if (hold)
            rcnt[sel] <= rcnt[sel] - 1'b1;
         else if (spike_in)
            rcnt[sel] <= RW'(REFRAC_STEPS);
      end
   end
`else
   logic unused_refrac;
   assign unused_refrac = REFRAC_STEPS[0];
   assign hold = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      acc_nxt   = acc;
      en        = '0;
      v_clr     = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick) begin
               state_nxt = LOAD;
               sel_nxt   = '0;
               acc_nxt   = '0;
            end
         end
         LOAD: state_nxt = WRITE;
         WRITE: begin
            en[sel]      = 1'b1;
            v_clr        = spike_in | hold;
            acc_nxt[sel] = spike_in & ~hold;
            if (last) begin
               state_nxt = DONE;
            end else begin
               sel_nxt   = sel + 1'b1;
               state_nxt = LOAD;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
            sel_nxt   = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         sel       <= '0;
         acc       <= '0;
         spike_vec <= '0;
         spike_cnt <= '0;
         overrun   <= 1'b0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         acc   <= acc_nxt;
         if (state == DONE) begin
            spike_vec <= acc;
            spike_cnt <= popcnt(acc);
         end
         if (tick && state != IDLE)
            overrun <= 1'b1;
      end
   end

endmodule
